// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizes the device clock/data, decodes
// start/data/parity/stop frames with an inactivity timeout, and queues words in a small FIFO.
module ps2_frame_rx #(
   parameter int unsigned DATA_W      = 8,
   parameter bit          PARITY_ODD  = 1'b1,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 2000
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              i_ps2_clk,
   input  logic                              i_ps2_data,
   output logic [DATA_W-1:0]                 o_data,
   output logic                              o_perr,
   output logic                              o_valid,
   input  logic                              i_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_level,
   output logic                              o_frame_err,
   output logic                              o_timeout,
   output logic                              o_overflow
);

   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

   // ---------------------------------------------------------------------------------------
   // Input synchronizers; all reset to 1 so reset release never looks like a falling edge.
   // ---------------------------------------------------------------------------------------
   logic clk_s1_q, clk_s2_q, clk_prev_q;
   logic data_s1_q, data_s2_q;
   logic ps2_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         data_s1_q  <= 1'b1;
         data_s2_q  <= 1'b1;
      end else begin
         clk_s1_q   <= i_ps2_clk;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         data_s1_q  <= i_ps2_data;
         data_s2_q  <= data_s1_q;
      end
   end

   assign ps2_edge = clk_prev_q & ~clk_s2_q;

   // ---------------------------------------------------------------------------------------
   // Frame decoder
   // ---------------------------------------------------------------------------------------
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              perr_q, perr_d;
   logic              frame_err_q, frame_err_d;
   logic              timeout_q, timeout_d;
   logic              push;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         timer_q     <= '0;
         shreg_q     <= '0;
         perr_q      <= 1'b0;
         frame_err_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         timer_q     <= timer_d;
         shreg_q     <= shreg_d;
         perr_q      <= perr_d;
         frame_err_q <= frame_err_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      timer_d     = timer_q;
      shreg_d     = shreg_q;
      perr_d      = perr_q;
      frame_err_d = 1'b0;
      timeout_d   = 1'b0;
      push        = 1'b0;

      if (state_q == StIdle) begin
         timer_d = '0;
      end else if (ps2_edge) begin
         timer_d = '0;
      end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
         // Device went quiet mid-frame: drop the partial word.
         state_d   = StIdle;
         bit_cnt_d = '0;
         timer_d   = '0;
         timeout_d = 1'b1;
      end else begin
         timer_d = timer_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (ps2_edge && !data_s2_q) begin
               state_d   = StData;
               bit_cnt_d = '0;
               shreg_d   = '0;
            end
         end
         StData: begin
            if (ps2_edge) begin
               shreg_d[bit_cnt_q] = data_s2_q;
               if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_d   = StParity;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         StParity: begin
            if (ps2_edge) begin
               // xor of data and parity is 1 when the total number of ones is odd
               perr_d  = (^shreg_q) ^ data_s2_q ^ PARITY_ODD;
               state_d = StStop;
            end
         end
         StStop: begin
            if (ps2_edge) begin
               if (data_s2_q) push = 1'b1;
               else           frame_err_d = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // Receive FIFO
   // ---------------------------------------------------------------------------------------
   logic [DATA_W:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             overflow_q, overflow_d;
   logic             pop, full, push_ok;

   always_comb begin
      pop        = (level_q != '0) && i_ready;
      full       = (level_q == LVL_W'(FIFO_DEPTH));
      push_ok    = push && (!full || pop);
      overflow_d = push && full && !pop;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop)      level_d = level_q + 1'b1;
      else if (!push_ok && pop) level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      end else if (push_ok) begin
         mem_q[wr_ptr_q] <= {perr_q, shreg_q};
      end
   end

   always_comb begin
      o_valid = (level_q != '0);
      o_data  = '0;
      o_perr  = 1'b0;
      if (o_valid) begin
         o_data = mem_q[rd_ptr_q][DATA_W-1:0];
         o_perr = mem_q[rd_ptr_q][DATA_W];
      end
   end

   assign o_level     = level_q;
   assign o_frame_err = frame_err_q;
   assign o_timeout   = timeout_q;
   assign o_overflow  = overflow_q;

endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 Parameter DATA_W, 8, number of data bits per frame.
REQ-002 Parameter PARITY_ODD, 1, 1 = odd parity, 0 = even parity.
REQ-003 Parameter FIFO_DEPTH, 4, receive FIFO entries (power of two, >=2).
REQ-004 Parameter TIMEOUT_CYC, 2000, clk cycles allowed between device-clock falling edges inside a frame.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 i_ps2_clk  in  1  device clock, asynchronous to clk.
REQ-008 i_ps2_data  in  1  device data, asynchronous to clk.
REQ-009 o_data  out  DATA_W  FIFO head data word.
REQ-010 o_perr  out  1  parity-error flag stored with the head word.
REQ-011 o_valid  out  1  FIFO non-empty.
REQ-012 i_ready  in  1  consumer accepts the head word.
REQ-013 o_level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
REQ-014 o_frame_err  out  1  one-cycle pulse: stop bit sampled 0.
REQ-015 o_timeout  out  1  one-cycle pulse: frame aborted by timeout.
REQ-016 o_overflow  out  1  one-cycle pulse: completed word dropped because FIFO full.

Function
REQ-017 i_ps2_clk and i_ps2_data SHALL each pass a 2-flop synchronizer; a third flop on clk SHALL hold the previous synchronized clk value.
REQ-018 Edge event = previous synchronized clk 1 and current 0; data SHALL be sampled from synchronized data in the edge-event cycle.
REQ-019 FSM states: IDLE, DATA, PARITY, STOP.
REQ-020 IDLE: on edge with data 0 -> DATA, bit counter 0, timer 0; on edge with data 1 -> stay IDLE, no flag.
REQ-021 DATA: each edge stores the bit at index = counter (LSB first); after bit DATA_W-1 -> PARITY.
REQ-022 PARITY: on edge, store the parity bit; perr = 1 when ones(data)+parity is even (PARITY_ODD=1) or odd (PARITY_ODD=0); -> STOP.
REQ-023 STOP: on edge with data 1, push {perr, data} into FIFO; with data 0, discard the word, pulse o_frame_err; either case -> IDLE.
REQ-024 Parity errors SHALL NOT discard the word; they are reported via o_perr only.
REQ-025 Pushed word SHALL appear on o_data/o_valid the cycle after the stop-bit edge event.
REQ-026 Timer: in DATA/PARITY/STOP, cleared on every edge, incremented otherwise; at TIMEOUT_CYC-1 without an edge -> IDLE, partial word discarded, o_timeout pulse next cycle. Timer held at 0 in IDLE.
REQ-027 Pop occurs when o_valid && i_ready; o_data/o_perr then advance to the next entry next cycle.
REQ-028 Push when full without a same-cycle pop SHALL drop the word and pulse o_overflow; push when full with a same-cycle pop SHALL succeed, level unchanged.
REQ-029 Push and pop in the same cycle when not full or empty: both succeed; level unchanged when not empty.
REQ-030 Push into an empty FIFO with i_ready high: the word SHALL be presented for at least one cycle before it can be popped.
REQ-031 When empty, o_data and o_perr SHALL be 0.
REQ-032 Read/write pointers SHALL wrap modulo FIFO_DEPTH; o_level SHALL range 0..FIFO_DEPTH.
REQ-033 Error pulses SHALL last exactly one clk cycle and SHALL not block reception of the next frame.

Reset
REQ-034 On rst_n low, all synchronizer and previous-clk flops SHALL reset to 1, so no edge event occurs on reset release.
REQ-035 On rst_n low: FSM SHALL enter IDLE, counters/timer 0, FIFO empty, all outputs 0.
REQ-036 Reset asserted mid-frame SHALL discard the partial word; the first frame started after release SHALL be received correctly.

Verification
REQ-037 Frame 0x5A, odd parity 1, stop 1, i_ready=1 -> o_valid 1 cycle, o_data=0x5A, o_perr=0, o_level back to 0.
REQ-038 Frame 0x5A with parity 0 -> word 0x5A pushed with o_perr=1.
REQ-039 Frame 0x33 with stop bit 0 -> o_frame_err single pulse, o_level stays 0.
REQ-040 Start + 3 bits, then device clock idle for TIMEOUT_CYC cycles -> o_timeout pulse, then frame 0x01 -> o_data=0x01.
REQ-041 i_ready=0, FIFO_DEPTH+1 frames 0x10..0x14 -> o_level=4, o_overflow pulse on 5th, pops return 0x10,0x11,0x12,0x13.
REQ-042 rst_n pulsed during bit 4 of a frame, then frame 0xC3 -> only 0xC3 is received, o_perr=0.
